// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the 4-digit 7-segment scanner.
//   - SEG_0..SEG_9, SEG_DASH, SEG_OFF : active-low glyphs, bit 6 = g .. bit 0 = a
//   - digit_idx_t                     : 2-bit digit/anode index
//   - scan_phase_t                    : per-slot phase (BLANK, DRIVE)
package seg7_pkg;

  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_phase_t;

endpackage

// File: rtl/seg7_scan_decode.sv
// seg7_decode: combinational BCD to active-low 7-segment glyph.
//   bcd   in  4  digit value; 0-9 map to numerals, 10-15 map to '-'
//   glyph out 7  active-low segments, bit 6 = g .. bit 0 = a
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = SEG_DASH;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexes four BCD digits onto a common-anode 4-digit
// 7-segment display, with per-digit decimal points, optional leading-zero
// suppression and an all-anodes-off window at the start of every slot to
// suppress ghosting.
//
// Optional feature macro: SEG7_BLINK_EN (whole-display blinking).
//
// Ports:
//   clk      in   1   system clock
//   rst_n    in   1   asynchronous active-low reset
//   digits   in  16   BCD digits, [15:12] = d3 (MSD) .. [3:0] = d0 (LSD)
//   dp_mask  in   4   1 = light decimal point of digit i
//   blank_lz in   1   1 = suppress leading zeros
//   blink    in   1   1 = flash whole display (only with SEG7_BLINK_EN)
//   seg      out  7   active-low segments, seg[6] = g .. seg[0] = a
//   dp       out  1   active-low decimal point
//   an       out  4   active-low anodes, an[i] selects digit i
module seg7_scan
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int BLINK_DIV = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_mask,
  input  logic        blank_lz,
  input  logic        blink,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  localparam int          CW          = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  // With no blanking window a slot starts directly in DRIVE.
  localparam scan_phase_t SLOT_PHASE0 = (BLANK_CYC > 0) ? BLANK : DRIVE;

  logic [CW-1:0] cnt_reg;
  digit_idx_t    idx_reg;
  scan_phase_t   state_reg;

  logic          slot_end;
  logic          blank_end;
  logic [3:0]    digit_arr [4];
  logic [3:1]    is_zero;
  logic [3:0]    lz_blank;
  logic [3:0]    digit_sel;
  logic [6:0]    glyph;
  logic          blink_hide;
  logic          force_blank;

  assign slot_end  = (cnt_reg == CNT_LAST);
  assign blank_end = (32'(cnt_reg) == 32'(BLANK_CYC - 1));

  // Digit i is suppressed when it and every more-significant digit are zero.
  // d0 is never suppressed so a zero value still shows "0".
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      assign digit_arr[gi] = digits[4*gi +: 4];
    end
    for (gi = 1; gi < 4; gi++) begin : g_lz
      assign is_zero[gi]  = (digit_arr[gi] == 4'd0);
      assign lz_blank[gi] = blank_lz & (&is_zero[3:gi]);
    end
  endgenerate
  assign lz_blank[0] = 1'b0;

  assign digit_sel = digit_arr[idx_reg];

  seg7_decode u_decode (
    .bcd   (digit_sel),
    .glyph (glyph)
  );

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_reg;
  logic          blink_hidden_reg;

  // Free-running slot counter; the phase toggles every BLINK_DIV slots
  // whether or not blink is asserted, so enabling blink mid-run stays in step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg    <= '0;
      blink_hidden_reg <= 1'b0;
    end else if (slot_end) begin
      if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
        blink_cnt_reg    <= '0;
        blink_hidden_reg <= ~blink_hidden_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + BW'(1);
      end
    end
  end

  assign blink_hide = blink & blink_hidden_reg;
`else
  logic unused_blink;
  assign unused_blink = blink ^ BLINK_DIV[0];
  assign blink_hide   = 1'b0;
`endif

  assign force_blank = lz_blank[idx_reg] | blink_hide;

  // state_reg tracks the phase of the current cnt_reg value; the outputs are
  // registered from it, giving one cycle of latency from cnt/idx/inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      idx_reg   <= '0;
      state_reg <= SLOT_PHASE0;
      an        <= 4'hF;
      seg       <= SEG_OFF;
      dp        <= 1'b1;
    end else begin
      if (slot_end) begin
        cnt_reg   <= '0;
        idx_reg   <= idx_reg + 2'd1;
        state_reg <= SLOT_PHASE0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
        if (blank_end) begin
          state_reg <= DRIVE;
        end
      end

      case (state_reg)
        DRIVE: begin
          if (force_blank) begin
            an  <= 4'hF;
            seg <= SEG_OFF;
            dp  <= 1'b1;
          end else begin
            an  <= ~(4'b0001 << idx_reg);
            seg <= glyph;
            dp  <= ~dp_mask[idx_reg];
          end
        end
        default: begin
          an  <= 4'hF;
          seg <= SEG_OFF;
          dp  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed checks of seg7_scan with SCAN_DIV=8, BLANK_CYC=2,
// BLINK_DIV=2. Each slot is checked cycle by cycle against hand-computed
// glyph/anode/dp values; expectations for blinking depend on SEG7_BLINK_EN.
module tb_seg7_scan;

  logic        clk;
  logic        rst_n;
  logic [15:0] digits;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic        blink;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [3:0] DARK = 4'hF;

  seg7_scan #(
    .SCAN_DIV  (8),
    .BLANK_CYC (2),
    .BLINK_DIV (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits   (digits),
    .dp_mask  (dp_mask),
    .blank_lz (blank_lz),
    .blink    (blink),
    .seg      (seg),
    .dp       (dp),
    .an       (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Checks ncyc cycles of one scan slot. The first two cycles are the
  // blanking window; exp_an == DARK means the whole slot must be dark.
  task automatic do_slot(input string tag, input int ncyc, input logic [3:0] exp_an,
                         input logic [6:0] exp_seg, input logic exp_dp);
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    for (int k = 0; k < ncyc; k++) begin
      @(posedge clk);
      #1;
      if (k < 2 || exp_an == DARK) begin
        ea = 4'hF; es = 7'h7F; ed = 1'b1;
      end else begin
        ea = exp_an; es = exp_seg; ed = exp_dp;
      end
      check_val($sformatf("%s c%0d an", tag, k), {4'h0, an}, {4'h0, ea});
      check_val($sformatf("%s c%0d seg", tag, k), {1'b0, seg}, {1'b0, es});
      check_val($sformatf("%s c%0d dp", tag, k), {7'h0, dp}, {7'h0, ed});
    end
    $display("slot %s: an=%b seg=%b dp=%b", tag, an, seg, dp);
  endtask

  // Asserts reset away from any clock edge, checks the reset values at once,
  // then releases on a falling edge so the next rising edge sees cnt=0.
  task automatic do_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_val({tag, " async an"}, {4'h0, an}, 8'h0F);
    check_val({tag, " async seg"}, {1'b0, seg}, 8'h7F);
    check_val({tag, " async dp"}, {7'h0, dp}, 8'h01);
    @(negedge clk);
    @(negedge clk);
    check_val({tag, " held an"}, {4'h0, an}, 8'h0F);
    rst_n = 1'b1;
    $display("reset %s released", tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    digits   = 16'h1234;
    dp_mask  = 4'b0000;
    blank_lz = 1'b0;
    blink    = 1'b0;
    repeat (3) @(negedge clk);
    check_val("por an", {4'h0, an}, 8'h0F);
    check_val("por seg", {1'b0, seg}, 8'h7F);
    check_val("por dp", {7'h0, dp}, 8'h01);
    rst_n = 1'b1;

    // Scan two slots, then five cycles into slot 2 (cnt=5, idx=2) and reset.
    do_slot("t1 s0", 8, 4'b1110, 7'b0011001, 1'b1);
    do_slot("t1 s1", 8, 4'b1101, 7'b0110000, 1'b1);
    do_slot("t1 s2p", 5, 4'b1011, 7'b0100100, 1'b1);
    do_reset("t1");

    // 1234, no suppression: first DRIVE at cycle 3 after release.
    do_slot("t2 s0", 8, 4'b1110, 7'b0011001, 1'b1);
    do_slot("t2 s1", 8, 4'b1101, 7'b0110000, 1'b1);
    do_slot("t2 s2", 8, 4'b1011, 7'b0100100, 1'b1);
    do_slot("t2 s3", 8, 4'b0111, 7'b1111001, 1'b1);

    // 0050 with leading-zero suppression: d3, d2 dark.
    digits   = 16'h0050;
    blank_lz = 1'b1;
    do_slot("t3 lz s0", 8, 4'b1110, 7'b1000000, 1'b1);
    do_slot("t3 lz s1", 8, 4'b1101, 7'b0010010, 1'b1);
    do_slot("t3 lz s2", 8, DARK, 7'h7F, 1'b1);
    do_slot("t3 lz s3", 8, DARK, 7'h7F, 1'b1);
    blank_lz = 1'b0;
    do_slot("t3 nolz s0", 8, 4'b1110, 7'b1000000, 1'b1);
    do_slot("t3 nolz s1", 8, 4'b1101, 7'b0010010, 1'b1);
    do_slot("t3 nolz s2", 8, 4'b1011, 7'b1000000, 1'b1);
    do_slot("t3 nolz s3", 8, 4'b0111, 7'b1000000, 1'b1);

    // Non-BCD digit shows a dash.
    digits = 16'h00A0;
    do_slot("t4 s0", 8, 4'b1110, 7'b1000000, 1'b1);
    do_slot("t4 s1", 8, 4'b1101, 7'b0111111, 1'b1);
    do_slot("t4 s2", 8, 4'b1011, 7'b1000000, 1'b1);
    do_slot("t4 s3", 8, 4'b0111, 7'b1000000, 1'b1);

    // Decimal point only on digit 2.
    digits  = 16'h1234;
    dp_mask = 4'b0100;
    do_slot("t5 s0", 8, 4'b1110, 7'b0011001, 1'b1);
    do_slot("t5 s1", 8, 4'b1101, 7'b0110000, 1'b1);
    do_slot("t5 s2", 8, 4'b1011, 7'b0100100, 1'b0);
    do_slot("t5 s3", 8, 4'b0111, 7'b1111001, 1'b1);

    // dp_mask is ignored on a suppressed digit.
    digits   = 16'h0050;
    blank_lz = 1'b1;
    dp_mask  = 4'b1100;
    do_slot("t5 lz s0", 8, 4'b1110, 7'b1000000, 1'b1);
    do_slot("t5 lz s1", 8, 4'b1101, 7'b0010010, 1'b1);
    do_slot("t5 lz s2", 8, DARK, 7'h7F, 1'b1);
    do_slot("t5 lz s3", 8, DARK, 7'h7F, 1'b1);

    // Blink: after reset the phase is visible for two slots, hidden for two.
    do_reset("t6");
    digits   = 16'h1234;
    blank_lz = 1'b0;
    dp_mask  = 4'b0000;
    blink    = 1'b1;
    for (int r = 0; r < 2; r++) begin
      do_slot($sformatf("t6 b%0d s0", r), 8, 4'b1110, 7'b0011001, 1'b1);
      do_slot($sformatf("t6 b%0d s1", r), 8, 4'b1101, 7'b0110000, 1'b1);
`ifdef SEG7_BLINK_EN
      do_slot($sformatf("t6 b%0d s2", r), 8, DARK, 7'h7F, 1'b1);
      do_slot($sformatf("t6 b%0d s3", r), 8, DARK, 7'h7F, 1'b1);
`else
      do_slot($sformatf("t6 b%0d s2", r), 8, 4'b1011, 7'b0100100, 1'b1);
      do_slot($sformatf("t6 b%0d s3", r), 8, 4'b0111, 7'b1111001, 1'b1);
`endif
    end
    blink = 1'b0;
    do_slot("t6 nb s0", 8, 4'b1110, 7'b0011001, 1'b1);
    do_slot("t6 nb s1", 8, 4'b1101, 7'b0110000, 1'b1);
    do_slot("t6 nb s2", 8, 4'b1011, 7'b0100100, 1'b1);
    do_slot("t6 nb s3", 8, 4'b0111, 7'b1111001, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
